// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority event drain.
// clog2_min1 keeps index buses at least one bit wide for tiny encoders.
package prio_pkg;

  typedef enum logic {IDLE, PRESENT} drain_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder, zero latency, no flow control.
// MSB_FIRST picks the highest set index, otherwise the lowest.
module prio_enc
  import prio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = clog2_min1(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  // The loop direction is chosen so the winning bit is the last one assigned.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |in_vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_event_drain.sv
// Accumulates event pulses and drains them as codes, 2 cycles evt_in to code_valid.
// code is held while code_ready=0; events on already-pending bits are counted as drops.
module prio_event_drain
  import prio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = clog2_min1(WIDTH),
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] evt_in,
  input  logic             clear,
  input  logic             code_ready,
  output logic             code_valid,
  output logic [IDX_W-1:0] code,
  output logic [WIDTH-1:0] pending,
  output logic [CNT_W-1:0] drop_cnt
);

  drain_state_t     state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] code_q, code_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0] take_mask;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [WIDTH-1:0] enc_onehot;

  prio_enc #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_enc (
    .in_vec(pending_q),
    .idx   (enc_idx),
    .any   (enc_any),
    .onehot(enc_onehot)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    code_d     = code_q;
    drop_cnt_d = drop_cnt_q;
    take_mask  = '0;
    if (clear) begin
      state_d   = IDLE;
      pending_d = '0;
      code_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_any) begin
            state_d   = PRESENT;
            code_d    = enc_idx;
            take_mask = enc_onehot;
          end
        end
        PRESENT: begin
          if (code_ready) begin
            if (enc_any) begin
              code_d    = enc_idx;
              take_mask = enc_onehot;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // OR-ing evt_in last lets a new event re-arm the bit being taken.
      pending_d = (pending_q & ~take_mask) | evt_in;
      if ((|(evt_in & pending_q)) && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      code_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign code_valid = (state_q == PRESENT);
  assign code       = code_q;
  assign pending    = pending_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
